// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : adc_spi_responder
// Description : SPI-style responder for a four-channel ADC. Each 16-sclk frame
//               shifts out {4'b0000, ch[cur_channel]} MSB first and captures a
//               2-bit channel address (rises 3 and 4) that selects the channel
//               returned in the following frame. sclk and cs_n are in the clk
//               domain and are edge-detected against registered copies.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_responder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        din,
    input  logic [11:0] ch0_data,
    input  logic [11:0] ch1_data,
    input  logic [11:0] ch2_data,
    input  logic [11:0] ch3_data,
    output logic        dout,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [1:0]  cur_channel
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0]  C_BIT_TOP    = 4'd15;
    localparam logic [4:0]  C_LAST_EDGE  = 5'd16;
    localparam logic [4:0]  C_ADDR_HI_EDGE = 5'd3;
    localparam logic [4:0]  C_ADDR_LO_EDGE = 5'd4;

    state_t       r_state;
    state_t       w_state_next;

    logic         r_sclk_q;
    logic         r_cs_q;
    logic         w_sclk_rise;
    logic         w_sclk_fall;
    logic         w_cs_rise;
    logic         w_cs_fall;

    logic [3:0]   r_bit_cnt;
    logic [3:0]   w_bit_cnt_next;
    logic [4:0]   r_edge_cnt;
    logic [4:0]   w_edge_cnt_next;
    logic [4:0]   w_edge_inc;
    logic [15:0]  r_snapshot;
    logic [15:0]  w_snapshot_next;
    logic [1:0]   r_addr_next;
    logic [1:0]   w_addr_next_next;
    logic [1:0]   r_cur_channel;
    logic [1:0]   w_cur_channel_next;
    logic         r_frame_abort;
    logic         w_frame_abort_next;
    logic         r_fall_pending;
    logic         w_fall_pending_next;
    logic         w_start;
    logic [11:0]  w_ch_sel;

    assign w_sclk_rise =  sclk & ~r_sclk_q;
    assign w_sclk_fall = ~sclk &  r_sclk_q;
    assign w_cs_rise   =  cs_n & ~r_cs_q;
    assign w_cs_fall   = ~cs_n &  r_cs_q;

    // A frame starts on a fresh cs_n fall, or on one that arrived during DONE
    // provided cs_n is still low when we get back to IDLE.
    assign w_start    = w_cs_fall | (r_fall_pending & ~cs_n);
    assign w_edge_inc = r_edge_cnt + 5'd1;

    // Channel mux feeding the snapshot load at frame start.
    always_comb begin
        w_ch_sel = ch0_data;
        case (r_cur_channel)
            2'd0:    w_ch_sel = ch0_data;
            2'd1:    w_ch_sel = ch1_data;
            2'd2:    w_ch_sel = ch2_data;
            2'd3:    w_ch_sel = ch3_data;
            default: w_ch_sel = ch0_data;
        endcase
    end

    // Edge-detect history registers for sclk and cs_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_q <= 1'b0;
            r_cs_q   <= 1'b1;
        end else begin
            r_sclk_q <= sclk;
            r_cs_q   <= cs_n;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath update decisions.
    always_comb begin
        w_state_next        = r_state;
        w_bit_cnt_next      = r_bit_cnt;
        w_edge_cnt_next     = r_edge_cnt;
        w_snapshot_next     = r_snapshot;
        w_addr_next_next    = r_addr_next;
        w_cur_channel_next  = r_cur_channel;
        w_frame_abort_next  = 1'b0;
        w_fall_pending_next = r_fall_pending;

        case (r_state)
            ST_IDLE: begin
                w_fall_pending_next = 1'b0;
                // Any sclk rise in the start cycle is deliberately not counted.
                if (w_start) begin
                    w_state_next     = ST_ACTIVE;
                    w_bit_cnt_next   = C_BIT_TOP;
                    w_edge_cnt_next  = 5'd0;
                    w_snapshot_next  = {4'b0000, w_ch_sel};
                    w_addr_next_next = 2'b00;
                end
            end

            ST_ACTIVE: begin
                if (w_sclk_rise && (r_edge_cnt < C_LAST_EDGE)) begin
                    // A 16th rise completes the frame even if cs_n rises with it.
                    w_edge_cnt_next = w_edge_inc;
                    if (w_edge_inc == C_ADDR_HI_EDGE) begin
                        w_addr_next_next[1] = din;
                    end
                    if (w_edge_inc == C_ADDR_LO_EDGE) begin
                        w_addr_next_next[0] = din;
                    end
                    if (w_edge_inc == C_LAST_EDGE) begin
                        w_state_next = ST_DONE;
                    end else if (w_cs_rise) begin
                        w_state_next       = ST_IDLE;
                        w_frame_abort_next = 1'b1;
                        w_addr_next_next   = 2'b00;
                    end
                end else if (w_cs_rise) begin
                    w_state_next       = ST_IDLE;
                    w_frame_abort_next = 1'b1;
                    w_addr_next_next   = 2'b00;
                end else if (w_sclk_fall && (r_bit_cnt != 4'd0)) begin
                    w_bit_cnt_next = r_bit_cnt - 4'd1;
                end
            end

            ST_DONE: begin
                w_state_next       = ST_IDLE;
                w_cur_channel_next = r_addr_next;
                if (w_cs_fall) begin
                    w_fall_pending_next = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt      <= C_BIT_TOP;
            r_edge_cnt     <= 5'd0;
            r_snapshot     <= 16'h0000;
            r_addr_next    <= 2'b00;
            r_cur_channel  <= 2'b00;
            r_frame_abort  <= 1'b0;
            r_fall_pending <= 1'b0;
        end else begin
            r_bit_cnt      <= w_bit_cnt_next;
            r_edge_cnt     <= w_edge_cnt_next;
            r_snapshot     <= w_snapshot_next;
            r_addr_next    <= w_addr_next_next;
            r_cur_channel  <= w_cur_channel_next;
            r_frame_abort  <= w_frame_abort_next;
            r_fall_pending <= w_fall_pending_next;
        end
    end

    // dout is gated by cs_n so it drops in the very cycle cs_n goes high.
    assign dout        = (r_state == ST_ACTIVE) & ~cs_n & r_snapshot[r_bit_cnt];
    assign frame_done  = (r_state == ST_DONE);
    assign frame_abort = r_frame_abort;
    assign cur_channel = r_cur_channel;

endmodule
`default_nettype wire

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is clk; the reset is reset_n, which is asynchronous and active-low.
REQ-002 Port: clk  input  1  system clock; sclk and cs_n are generated in this same clock domain, so no synchronizers.
REQ-003 Port: reset_n  input  1  asynchronous active-low reset.
REQ-004 Port: cs_n  input  1  frame select, active low.
REQ-005 Port: sclk  input  1  serial clock, sampled as a level on clk; minimum 1 clk high and 1 clk low.
REQ-006 Port: din  input  1  serial address from the initiator, MSB first.
REQ-007 Port: ch0_data, ch1_data, ch2_data, ch3_data  input  12 each  conversion values for channels 0-3.
REQ-008 Port: dout  output  1  serial conversion data to the initiator.
REQ-009 Port: frame_done  output  1  one-clk pulse when a complete 16-bit frame ends.
REQ-010 Port: frame_abort  output  1  one-clk pulse when cs_n rises before the frame completes.
REQ-011 Port: cur_channel  output  2  channel whose data is being, or will next be, shifted out.

Function
REQ-012 The block SHALL detect sclk edges against a registered copy sclk_q: rise = sclk & ~sclk_q; fall = ~sclk & sclk_q.
REQ-013 The block SHALL detect cs_n edges against a registered copy cs_q in the same way.
REQ-014 The FSM SHALL have states IDLE, ACTIVE and DONE.
REQ-015 IDLE->ACTIVE on a cs_n falling edge; in that cycle the block SHALL set bit_cnt=15 and load shift word {4'b0000, ch[cur_channel]} into a 16-bit snapshot register.
REQ-016 The block SHALL ignore an sclk rise in the same cycle as the cs_n falling edge (it is neither counted nor sampled).
REQ-017 While ACTIVE, dout SHALL equal snapshot bit bit_cnt; bit 15 SHALL be valid from the cycle after the cs_n fall.
REQ-018 While ACTIVE, each sclk fall SHALL decrement bit_cnt when bit_cnt>0, so the next bit is valid from the following cycle, before the next rise.
REQ-019 While ACTIVE, each sclk rise SHALL be counted as edge n (1..16).
REQ-020 The block SHALL sample din on rise 3 into addr_next[1] and on rise 4 into addr_next[0].
REQ-021 On rise 16 the FSM SHALL go ACTIVE->DONE; in DONE it SHALL assert frame_done for exactly 1 clk and load cur_channel<=addr_next.
REQ-022 DONE->IDLE unconditionally after 1 clk.
REQ-023 The new cur_channel SHALL therefore apply to the next frame, not the current one.
REQ-024 After rise 16, further sclk edges SHALL be ignored and dout SHALL be 0 until cs_n rises and falls again.
REQ-025 A cs_n rise while ACTIVE with fewer than 16 rises SHALL pulse frame_abort for 1 clk, return the FSM to IDLE, leave cur_channel unchanged and discard addr_next.
REQ-026 dout SHALL be 0 whenever the FSM is IDLE or cs_n is high; there is no tri-state.
REQ-027 Changes on ch*_data after the snapshot SHALL NOT affect the current frame.
REQ-028 In DONE, a cs_n falling edge SHALL be held off and taken in IDLE only if cs_n is still low; a new frame requires a fresh cs_n falling edge.
REQ-029 frame_done and frame_abort SHALL never assert in the same cycle.
REQ-030 The edge counter SHALL saturate at 16 and SHALL never wrap.

Reset
REQ-031 On reset_n low, asynchronously: state=IDLE, bit_cnt=15, edge count=0, snapshot=0, addr_next=0, cur_channel=0, dout=0, frame_done=0, frame_abort=0, sclk_q=0, cs_q=1.
REQ-032 A reset mid-frame SHALL discard the frame; after release, no pulse is produced until a new cs_n falling edge.

Verification
REQ-033 Set ch0=12'hA5C and drive one 16-sclk frame with din=0 -> dout stream 0000_1010_0101_1100 MSB first, frame_done is one 1-clk pulse, cur_channel=0.
REQ-034 Drive frame 1 with din bits 13,12 = 1,0 and ch2=12'h123, then frame 2 -> frame 1 returns ch0 data, cur_channel=2 after frame 1, frame 2 returns 0000_0001_0010_0011.
REQ-035 Raise cs_n after 8 rises in a frame carrying address 3 -> frame_abort pulses once, frame_done stays 0, cur_channel is unchanged, dout=0.
REQ-036 Change ch0 from 12'hFFF to 12'h000 at rise 6 -> the shifted data bits are all ones.
REQ-037 Drive 20 sclk rises in one cs_n-low window -> exactly one frame_done, dout=0 after rise 16, edges 17-20 have no effect.
REQ-038 Pulse reset_n low at rise 10, then run a full frame -> no frame_done or frame_abort from the aborted frame, cur_channel=0, the new frame is correct.
